// File: rtl/coherence_bus_ctrl.sv
// Purpose: N-CPU MSI snooping bus controller; round-robin arbitration of I/D cache requests onto one RAM port.
// Latency: one IDLE cycle to register the grant, then one RAM ACCESS per word (plus one SNOOP cycle for coherence misses).
// Backpressure: per-CPU iwait/dwait stay high until the RAM reports ACCESS; FREE/BUSY/ERROR hold all state.
module coherence_bus_ctrl #(
  parameter int CPUS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CPUS-1:0]     iREN,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  logic [CPUS*32-1:0]  iaddr,
  input  logic [CPUS*32-1:0]  daddr,
  input  logic [CPUS*32-1:0]  dstore,
  input  logic [CPUS-1:0]     ccwrite,
  input  logic [CPUS-1:0]     cctrans,
  output logic [CPUS-1:0]     iwait,
  output logic [CPUS-1:0]     dwait,
  output logic [CPUS*32-1:0]  iload,
  output logic [CPUS*32-1:0]  dload,
  output logic [CPUS-1:0]     ccwait,
  output logic [CPUS-1:0]     ccinv,
  output logic [CPUS*32-1:0]  ccsnoopaddr,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [31:0]         ramaddr,
  output logic [31:0]         ramstore,
  input  logic [31:0]         ramload,
  input  logic [1:0]          ramstate
);

  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [2:0] LAST_WORD = 3'(BLKWORDS - 1);

  typedef logic [GW-1:0] idx_t;
  typedef enum logic [2:0] {IDLE, WB, SNOOP, FWD, MEMRD, IFETCH} state_t;

  state_t     state_q, state_d;
  idx_t       gnt_q, gnt_d;
  idx_t       src_q, src_d;
  idx_t       rr_q, rr_d;
  logic [2:0] cnt_q, cnt_d;

  logic [CPUS-1:0] wb_req, cc_req, fwd_vec;
  logic [31:0]     daddr_g, dstore_g, iaddr_g, daddr_s, dstore_s;
  logic            access, live;

  // First set bit at or after ptr, wrapping round to index 0.
  function automatic idx_t rr_pick(input logic [CPUS-1:0] vec, input idx_t ptr);
    idx_t pick;
    logic found;
    int   idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < CPUS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= CPUS) idx = idx - CPUS;
      if (!found && vec[idx]) begin
        found = 1'b1;
        pick  = idx_t'(idx);
      end
    end
    return pick;
  endfunction

  // Lowest set bit; forwarding source selection.
  function automatic idx_t lowest(input logic [CPUS-1:0] vec);
    idx_t pick;
    pick = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (vec[j]) pick = idx_t'(j);
    end
    return pick;
  endfunction

  assign wb_req   = dWEN & ~cctrans;
  assign cc_req   = dREN & cctrans;
  assign access   = (ramstate == 2'd2);
  assign daddr_g  = daddr[gnt_q*32 +: 32];
  assign dstore_g = dstore[gnt_q*32 +: 32];
  assign iaddr_g  = iaddr[gnt_q*32 +: 32];
  assign daddr_s  = daddr[src_q*32 +: 32];
  assign dstore_s = dstore[src_q*32 +: 32];

  // Snoopers holding the block modified and offering its data; the requester never counts.
  always_comb begin
    fwd_vec        = ccwrite & dWEN;
    fwd_vec[gnt_q] = 1'b0;
  end

  // The granted requester still holds the request that started this transaction.
  always_comb begin
    live = 1'b0;
    case (state_q)
      WB:                live = wb_req[gnt_q];
      SNOOP, FWD, MEMRD: live = cc_req[gnt_q];
      IFETCH:            live = iREN[gnt_q];
      default:           live = 1'b0;
    endcase
  end

  // Next-state, grant, word counter and round-robin pointer.
  always_comb begin
    logic done;
    done    = 1'b0;
    state_d = state_q;
    gnt_d   = gnt_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (|wb_req) begin
          gnt_d   = rr_pick(wb_req, rr_q);
          state_d = WB;
        end else if (|cc_req) begin
          gnt_d   = rr_pick(cc_req, rr_q);
          state_d = (CPUS > 1) ? SNOOP : MEMRD;
        end else if (|iREN) begin
          gnt_d   = rr_pick(iREN, rr_q);
          state_d = IFETCH;
        end
      end
      SNOOP: begin
        if (!live) begin
          state_d = IDLE;
        end else if (|fwd_vec) begin
          src_d   = lowest(fwd_vec);
          state_d = FWD;
        end else begin
          state_d = MEMRD;
        end
      end
      WB, FWD, MEMRD: begin
        if (!live) state_d = IDLE;
        else if (access) begin
          if (cnt_q == LAST_WORD) done = 1'b1;
          else cnt_d = cnt_q + 3'd1;
        end
      end
      IFETCH: begin
        if (!live) state_d = IDLE;
        else if (access) done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      rr_d    = (gnt_q == idx_t'(CPUS - 1)) ? '0 : gnt_q + 1'b1;
    end
    if (state_d == IDLE) cnt_d = '0;
  end

  // Bus outputs decoded from the current state; handshake pulses follow ramstate directly.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (live) begin
      if (state_q inside {SNOOP, FWD, MEMRD}) begin
        for (int j = 0; j < CPUS; j++) begin
          if (j != int'(gnt_q)) begin
            ccwait[j]                = 1'b1;
            ccinv[j]                 = ccwrite[gnt_q];
            ccsnoopaddr[j*32 +: 32]  = daddr_g;
          end
        end
      end
      case (state_q)
        WB: begin
          ramWEN   = 1'b1;
          ramaddr  = daddr_g;
          ramstore = dstore_g;
          if (access) dwait[gnt_q] = 1'b0;
        end
        FWD: begin
          dload[gnt_q*32 +: 32] = dstore_s;
          ramWEN   = 1'b1;
          ramaddr  = daddr_s;
          ramstore = dstore_s;
          if (access) begin
            dwait[gnt_q] = 1'b0;
            dwait[src_q] = 1'b0;
          end
        end
        MEMRD: begin
          ramREN  = 1'b1;
          ramaddr = daddr_g;
          if (access) begin
            dload[gnt_q*32 +: 32] = ramload;
            dwait[gnt_q]          = 1'b0;
          end
        end
        IFETCH: begin
          ramREN  = 1'b1;
          ramaddr = iaddr_g;
          if (access) begin
            iload[gnt_q*32 +: 32] = ramload;
            iwait[gnt_q]          = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      src_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
module tb_coherence_bus_ctrl;

  localparam int CPUS = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic         CLK, nRST;
  logic [3:0]   iREN, dREN, dWEN, ccwrite, cctrans;
  logic [127:0] iaddr, daddr, dstore;
  logic [3:0]   iwait, dwait, ccwait, ccinv;
  logic [127:0] iload, dload, ccsnoopaddr;
  logic         ramREN, ramWEN;
  logic [31:0]  ramaddr, ramstore, ramload;
  logic [1:0]   ramstate;

  int checks = 0;
  int errors = 0;

  coherence_bus_ctrl #(.CPUS(CPUS), .BLKWORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite), .cctrans(cctrans),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM contents model: every word reads back as its address xor a fixed tag.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hCAFE0000;
  endfunction
  assign ramload = memf(ramaddr);

  function automatic logic [127:0] lane(input int j, input logic [31:0] v);
    logic [127:0] r;
    r = '0;
    r[j*32 +: 32] = v;
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramstate = FREE;
  endtask

  task automatic rand_inputs();
    iREN = 4'($urandom); dREN = 4'($urandom); dWEN = 4'($urandom);
    ccwrite = 4'($urandom); cctrans = 4'($urandom);
    iaddr  = {$urandom, $urandom, $urandom, $urandom};
    daddr  = {$urandom, $urandom, $urandom, $urandom};
    dstore = {$urandom, $urandom, $urandom, $urandom};
    ramstate = 2'($urandom_range(0, 3));
  endtask

  typedef struct {
    logic [3:0]   iren;
    logic [1:0]   rs;
    logic [3:0]   iwait_e;
    logic         ren_e;
    logic [31:0]  raddr_e;
    logic [127:0] iload_e;
  } vec_t;

  vec_t tv[16];

  initial begin
    // Round-robin instruction fetch, then ERROR/BUSY must not complete a fetch.
    tv[0]  = '{4'b1111, ACC,  4'b1111, 1'b0, 32'h0,    128'h0};
    tv[1]  = '{4'b1111, ACC,  4'b1110, 1'b1, 32'h1000, lane(0, memf(32'h1000))};
    tv[2]  = '{4'b1111, ACC,  4'b1111, 1'b0, 32'h0,    128'h0};
    tv[3]  = '{4'b1111, ACC,  4'b1101, 1'b1, 32'h1010, lane(1, memf(32'h1010))};
    tv[4]  = '{4'b1111, ACC,  4'b1111, 1'b0, 32'h0,    128'h0};
    tv[5]  = '{4'b1111, ACC,  4'b1011, 1'b1, 32'h1020, lane(2, memf(32'h1020))};
    tv[6]  = '{4'b1111, ACC,  4'b1111, 1'b0, 32'h0,    128'h0};
    tv[7]  = '{4'b1111, ACC,  4'b0111, 1'b1, 32'h1030, lane(3, memf(32'h1030))};
    tv[8]  = '{4'b1111, ACC,  4'b1111, 1'b0, 32'h0,    128'h0};
    tv[9]  = '{4'b1111, ACC,  4'b1110, 1'b1, 32'h1000, lane(0, memf(32'h1000))};
    tv[10] = '{4'b1111, ERR,  4'b1111, 1'b0, 32'h0,    128'h0};
    tv[11] = '{4'b1111, ERR,  4'b1111, 1'b1, 32'h1010, 128'h0};
    tv[12] = '{4'b1111, BUSY, 4'b1111, 1'b1, 32'h1010, 128'h0};
    tv[13] = '{4'b1111, ACC,  4'b1101, 1'b1, 32'h1010, lane(1, memf(32'h1010))};
    tv[14] = '{4'b0000, FREE, 4'b1111, 1'b0, 32'h0,    128'h0};
    tv[15] = '{4'b0000, FREE, 4'b1111, 1'b0, 32'h0,    128'h0};

    // Reset with random inputs.
    nRST = 1'b0;
    rand_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      check("rst_iwait", iwait, 4'b1111);
      check("rst_dwait", dwait, 4'b1111);
      check("rst_ramren", ramREN, 1'b0);
      check("rst_ramwen", ramWEN, 1'b0);
      check("rst_ccwait", ccwait, 4'b0000);
      rand_inputs();
    end
    clear_inputs();
    tick();
    nRST = 1'b1;

    // Table-driven fetch rounds.
    iaddr = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
    for (int i = 0; i < 16; i++) begin
      iREN = tv[i].iren;
      ramstate = tv[i].rs;
      @(negedge CLK);
      check($sformatf("v%0d_iwait", i), iwait, tv[i].iwait_e);
      check($sformatf("v%0d_ramren", i), ramREN, tv[i].ren_e);
      check($sformatf("v%0d_ramaddr", i), ramaddr, tv[i].raddr_e);
      check($sformatf("v%0d_iload", i), iload, tv[i].iload_e);
      check($sformatf("v%0d_ramwen", i), ramWEN, 1'b0);
      tick();
    end
    clear_inputs();

    // BusRdX by CPU1, no modified copy elsewhere: invalidate others, read from RAM.
    dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[63:32] = 32'h100;
    @(negedge CLK);
    check("t3_idle_dwait", dwait, 4'b1111);
    tick();
    @(negedge CLK);
    check("t3_snoop_ccwait", ccwait, 4'b1101);
    check("t3_snoop_ccinv", ccinv, 4'b1101);
    check("t3_snoop_addr", ccsnoopaddr, {32'h100, 32'h100, 32'h0, 32'h100});
    check("t3_snoop_ramren", ramREN, 1'b0);
    tick();
    ramstate = ACC;
    @(negedge CLK);
    check("t3_rd0_ramaddr", ramaddr, 32'h100);
    check("t3_rd0_dwait", dwait, 4'b1101);
    check("t3_rd0_dload", dload, lane(1, memf(32'h100)));
    check("t3_rd0_ccinv", ccinv, 4'b1101);
    tick();
    daddr[63:32] = 32'h104;
    @(negedge CLK);
    check("t3_rd1_ramaddr", ramaddr, 32'h104);
    check("t3_rd1_dwait", dwait, 4'b1101);
    check("t3_rd1_dload", dload, lane(1, memf(32'h104)));
    tick();
    clear_inputs();
    @(negedge CLK);
    check("t3_end_ccwait", ccwait, 4'b0000);
    check("t3_end_ramren", ramREN, 1'b0);

    // BusRd by CPU0 answered by CPU2 holding the block modified.
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[31:0] = 32'h200;
    tick();
    dWEN[2] = 1'b1; ccwrite[2] = 1'b1; dstore[95:64] = 32'hDEADBEEF; daddr[95:64] = 32'h200;
    @(negedge CLK);
    check("t4_snoop_ccwait", ccwait, 4'b1110);
    check("t4_snoop_ccinv", ccinv, 4'b0000);
    tick();
    ramstate = ACC;
    @(negedge CLK);
    check("t4_fwd0_ramwen", ramWEN, 1'b1);
    check("t4_fwd0_ramren", ramREN, 1'b0);
    check("t4_fwd0_ramaddr", ramaddr, 32'h200);
    check("t4_fwd0_ramstore", ramstore, 32'hDEADBEEF);
    check("t4_fwd0_dload", dload, lane(0, 32'hDEADBEEF));
    check("t4_fwd0_dwait", dwait, 4'b1010);
    tick();
    dstore[95:64] = 32'hFEEDF00D; daddr[95:64] = 32'h204; daddr[31:0] = 32'h204;
    @(negedge CLK);
    check("t4_fwd1_dload", dload, lane(0, 32'hFEEDF00D));
    check("t4_fwd1_dwait", dwait, 4'b1010);
    check("t4_fwd1_ramaddr", ramaddr, 32'h204);
    tick();
    clear_inputs();

    // CPU3 writeback and CPU0 fetch arrive together; writeback goes first.
    dWEN[3] = 1'b1; daddr[127:96] = 32'h300; dstore[127:96] = 32'h33330000;
    iREN[0] = 1'b1; iaddr[31:0] = 32'h1000; ramstate = ACC;
    @(negedge CLK);
    check("t5_idle_iwait", iwait, 4'b1111);
    tick();
    @(negedge CLK);
    check("t5_wb0_ramwen", ramWEN, 1'b1);
    check("t5_wb0_ramaddr", ramaddr, 32'h300);
    check("t5_wb0_ramstore", ramstore, 32'h33330000);
    check("t5_wb0_dwait", dwait, 4'b0111);
    check("t5_wb0_iwait", iwait, 4'b1111);
    tick();
    daddr[127:96] = 32'h304; dstore[127:96] = 32'h33330001;
    @(negedge CLK);
    check("t5_wb1_ramaddr", ramaddr, 32'h304);
    check("t5_wb1_dwait", dwait, 4'b0111);
    check("t5_wb1_iwait", iwait, 4'b1111);
    tick();
    dWEN[3] = 1'b0;
    @(negedge CLK);
    check("t5_gap_iwait", iwait, 4'b1111);
    check("t5_gap_ramwen", ramWEN, 1'b0);
    tick();
    @(negedge CLK);
    check("t5_if_iwait", iwait, 4'b1110);
    check("t5_if_iload", iload, lane(0, memf(32'h1000)));
    tick();
    clear_inputs();

    // CPU2 coherence read stalls on BUSY, then reset mid-transaction.
    dREN[2] = 1'b1; cctrans[2] = 1'b1; daddr[95:64] = 32'h400;
    tick();
    tick();
    ramstate = ACC;
    @(negedge CLK);
    check("t6_rd0_dwait", dwait, 4'b1011);
    check("t6_rd0_dload", dload, lane(2, memf(32'h400)));
    tick();
    ramstate = BUSY;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check($sformatf("t6_busy%0d_dwait", c), dwait, 4'b1111);
      check($sformatf("t6_busy%0d_ramren", c), ramREN, 1'b1);
      tick();
    end
    nRST = 1'b0;
    #1;
    check("t6_rst_iwait", iwait, 4'b1111);
    check("t6_rst_dwait", dwait, 4'b1111);
    check("t6_rst_ram", {ramREN, ramWEN, ramaddr}, 34'h0);
    check("t6_rst_cc", {ccwait, ccinv}, 8'h00);
    check("t6_rst_dload", dload, 128'h0);
    tick();
    clear_inputs();
    tick();
    nRST = 1'b1;

    // Pointer restarts at CPU0 after reset.
    iREN = 4'b1011; iaddr = {32'h1030, 32'h1020, 32'h1010, 32'h1000}; ramstate = ACC;
    tick();
    @(negedge CLK);
    check("t6_rr_iwait", iwait, 4'b1110);
    tick();
    clear_inputs();

    // Counter restarts: a full two-word block is still required.
    dREN[2] = 1'b1; cctrans[2] = 1'b1; daddr[95:64] = 32'h400;
    tick();
    tick();
    ramstate = ACC;
    @(negedge CLK);
    check("t6_blk0_dwait", dwait, 4'b1011);
    tick();
    @(negedge CLK);
    check("t6_blk1_dwait", dwait, 4'b1011);
    check("t6_blk1_ccwait", ccwait, 4'b1011);
    tick();
    clear_inputs();
    @(negedge CLK);
    check("t6_end_ccwait", ccwait, 4'b0000);
    check("t6_end_dwait", dwait, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
